// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Raster timing generator for 640x480@60 Hz VGA (800x525 total) on the pixel clock.
//   A free-running h/v counter pair is decoded into the scan interface. Every output
//   is registered, so each one lags the counter value it was decoded from by one clock.
//   Delayed copies of hs/vs/blank absorb the downstream mapper latency.
//
//   Optional feature: define VGA_TIMING_FRAME_COUNT_EN to build the 16-bit frame
//   counter. When the macro is undefined, frame_count is tied to zero.
//
// Ports
//   vga_clk      in   pixel clock
//   reset_n      in   asynchronous active-low reset
//   DrawX        out  current pixel column (counts through blanking)
//   DrawY        out  current pixel row (counts through blanking)
//   blank        out  1 = visible region
//   hs, vs       out  active-low syncs
//   blank_dly    out  blank delayed by PIPE_DELAY clocks
//   hs_dly       out  hs delayed by PIPE_DELAY clocks
//   vs_dly       out  vs delayed by PIPE_DELAY clocks
//   line_start   out  one-clock pulse at DrawX == 0
//   frame_start  out  one-clock pulse at DrawX == 0, DrawY == 0
//   frame_count  out  frames started since reset (wraps at 16 bits)
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE  = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_VISIBLE  = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned PIPE_DELAY = 2
) (
  input  logic        vga_clk,
  input  logic        reset_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        blank,
  output logic        hs,
  output logic        vs,
  output logic        blank_dly,
  output logic        hs_dly,
  output logic        vs_dly,
  output logic        line_start,
  output logic        frame_start,
  output logic [15:0] frame_count
);

  localparam int unsigned HTotal = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast      = 10'(HTotal - 1);
  localparam logic [9:0] VLast      = 10'(VTotal - 1);
  localparam logic [9:0] HVis       = 10'(H_VISIBLE);
  localparam logic [9:0] VVis       = 10'(V_VISIBLE);
  localparam logic [9:0] HSyncStart = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HSyncEnd   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VSyncEnd   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] r_h_cnt, r_v_cnt;
  logic [9:0] w_h_next, w_v_next;
  logic       w_blank, w_hs, w_vs, w_line_start, w_frame_start;

  logic [9:0] r_draw_x, r_draw_y;
  logic       r_blank, r_hs, r_vs, r_line_start, r_frame_start;

  // Counter advance: v only moves on the h wrap, both wrap together at frame end.
  always_comb begin
    w_h_next = r_h_cnt + 10'd1;
    w_v_next = r_v_cnt;
    if (r_h_cnt == HLast) begin
      w_h_next = '0;
      if (r_v_cnt == VLast) begin
        w_v_next = '0;
      end else begin
        w_v_next = r_v_cnt + 10'd1;
      end
    end
  end

  // Decode of the current count; registered below to give exactly one clock of latency.
  always_comb begin
    w_blank       = (r_h_cnt < HVis) && (r_v_cnt < VVis);
    w_hs          = !((r_h_cnt >= HSyncStart) && (r_h_cnt < HSyncEnd));
    w_vs          = !((r_v_cnt >= VSyncStart) && (r_v_cnt < VSyncEnd));
    w_line_start  = (r_h_cnt == '0);
    w_frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_draw_x      <= '0;
      r_draw_y      <= '0;
      r_blank       <= 1'b0;
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_h_cnt       <= w_h_next;
      r_v_cnt       <= w_v_next;
      r_draw_x      <= r_h_cnt;
      r_draw_y      <= r_v_cnt;
      r_blank       <= w_blank;
      r_hs          <= w_hs;
      r_vs          <= w_vs;
      r_line_start  <= w_line_start;
      r_frame_start <= w_frame_start;
    end
  end

  assign DrawX       = r_draw_x;
  assign DrawY       = r_draw_y;
  assign blank       = r_blank;
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

  // Delay lines for the monitor-side copies.
  generate
    if (PIPE_DELAY == 0) begin : g_no_dly
      assign blank_dly = r_blank;
      assign hs_dly    = r_hs;
      assign vs_dly    = r_vs;
    end else begin : g_dly
      logic [PIPE_DELAY-1:0] r_blank_pipe, r_hs_pipe, r_vs_pipe;
      // Chain bit 0 is the undelayed output; stage k holds it delayed by k+1 clocks.
      logic [PIPE_DELAY:0]   w_blank_chain, w_hs_chain, w_vs_chain;

      assign w_blank_chain = {r_blank_pipe, r_blank};
      assign w_hs_chain    = {r_hs_pipe, r_hs};
      assign w_vs_chain    = {r_vs_pipe, r_vs};

      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          r_blank_pipe <= '0;
          r_hs_pipe    <= '1;
          r_vs_pipe    <= '1;
        end else begin
          r_blank_pipe <= w_blank_chain[PIPE_DELAY-1:0];
          r_hs_pipe    <= w_hs_chain[PIPE_DELAY-1:0];
          r_vs_pipe    <= w_vs_chain[PIPE_DELAY-1:0];
        end
      end

      assign blank_dly = r_blank_pipe[PIPE_DELAY-1];
      assign hs_dly    = r_hs_pipe[PIPE_DELAY-1];
      assign vs_dly    = r_vs_pipe[PIPE_DELAY-1];
    end
  endgenerate

`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  // Counts on the same edge that registers frame_start, so the two appear together.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_count <= '0;
    end else if (w_frame_start) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = '0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Horizontal timing keeps its 640x480 values; the
// vertical timing is shrunk (6 visible, 2 FP, 2 sync, 3 BP = 13 lines, 10400 clocks per
// frame) so that several whole frames fit in a short run. With these values vs is low on
// DrawY 8..9 and blank is low on DrawY 6..12.
module tb_vga_timing_gen;

  localparam int unsigned FrameClks = 800 * 13;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  localparam bit FcEn = 1'b1;
`else
  localparam bit FcEn = 1'b0;
`endif

  logic        vga_clk;
  logic        reset_n;
  logic [9:0]  draw_x, draw_y;
  logic        blank, hs, vs, blank_dly, hs_dly, vs_dly, line_start, frame_start;
  logic [15:0] frame_count;

  int n_asserts = 0;
  int n_fail    = 0;
  int cyc       = 0;

  vga_timing_gen #(
    .H_VISIBLE  (640),
    .H_FP       (16),
    .H_SYNC     (96),
    .H_BP       (48),
    .V_VISIBLE  (6),
    .V_FP       (2),
    .V_SYNC     (2),
    .V_BP       (3),
    .PIPE_DELAY (2)
  ) u_dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (draw_x),
    .DrawY       (draw_y),
    .blank       (blank),
    .hs          (hs),
    .vs          (vs),
    .blank_dly   (blank_dly),
    .hs_dly      (hs_dly),
    .vs_dly      (vs_dly),
    .line_start  (line_start),
    .frame_start (frame_start),
    .frame_count (frame_count)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
    cyc++;
  endtask

  task automatic run_until(input logic [9:0] x, input logic [9:0] y, input int budget);
    int n;
    n = 0;
    while (!(draw_x == x && draw_y == y) && n < budget) begin
      tick();
      n++;
    end
    check("reach_xy", {12'd0, draw_y, draw_x}, {12'd0, y, x});
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_x"}, 32'(draw_x), 0);
    check({tag, "_y"}, 32'(draw_y), 0);
    check({tag, "_blank"}, 32'(blank), 0);
    check({tag, "_hs"}, 32'(hs), 1);
    check({tag, "_vs"}, 32'(vs), 1);
    check({tag, "_blank_dly"}, 32'(blank_dly), 0);
    check({tag, "_hs_dly"}, 32'(hs_dly), 1);
    check({tag, "_vs_dly"}, 32'(vs_dly), 1);
    check({tag, "_ls"}, 32'(line_start), 0);
    check({tag, "_fs"}, 32'(frame_start), 0);
    check({tag, "_fc"}, 32'(frame_count), 0);
  endtask

  initial begin
    int blank_hi, hs_lo, hs_first, hs_last, ls_cnt, ls_prev, ls_period;
    int vs_lo, vs_dly_lo, vs_min, vs_max, blank_dly_hi, fs_cnt, blank_bad;

    // Reset held for 5 clocks.
    reset_n = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check_reset_values("rst");

    reset_n = 1'b1;
    cyc = 0;
    tick();  // 1st edge: count (0,0) shown
    check("e1_x", 32'(draw_x), 0);
    check("e1_y", 32'(draw_y), 0);
    check("e1_blank", 32'(blank), 1);
    check("e1_ls", 32'(line_start), 1);
    check("e1_fs", 32'(frame_start), 1);
    check("e1_fc", 32'(frame_count), FcEn ? 1 : 0);
    tick();  // 2nd edge
    check("e2_x", 32'(draw_x), 1);
    check("e2_fs", 32'(frame_start), 0);
    check("e2_ls", 32'(line_start), 0);

    // One full line window: DrawX 2..799 of line 0, then 0..1 of line 1.
    blank_hi = 0; hs_lo = 0; hs_first = -1; hs_last = -1; ls_cnt = 0; ls_prev = 1;
    ls_period = 0;
    for (int i = 0; i < 800; i++) begin
      tick();
      if (blank) blank_hi++;
      if (!hs) begin
        hs_lo++;
        if (hs_first < 0) hs_first = int'(draw_x);
        hs_last = int'(draw_x);
      end
      if (line_start) begin
        ls_cnt++;
        ls_period = cyc - ls_prev;
        ls_prev = cyc;
      end
    end
    check("line_blank_hi", 32'(blank_hi), 640);
    check("line_hs_lo", 32'(hs_lo), 96);
    check("line_hs_first", 32'(hs_first), 656);
    check("line_hs_last", 32'(hs_last), 751);
    check("line_ls_cnt", 32'(ls_cnt), 1);
    check("line_ls_period", 32'(ls_period), 800);

    // Delayed outputs around the blank and hs edges on line 1.
    run_until(10'd639, 10'd1, 1000);
    check("d639_blank", 32'(blank), 1);
    check("d639_blank_dly", 32'(blank_dly), 1);
    tick();
    check("d640_blank", 32'(blank), 0);
    check("d640_blank_dly", 32'(blank_dly), 1);
    tick();
    check("d641_blank_dly", 32'(blank_dly), 1);
    tick();
    check("d642_blank_dly", 32'(blank_dly), 0);
    run_until(10'd655, 10'd1, 100);
    check("d655_hs", 32'(hs), 1);
    check("d655_hs_dly", 32'(hs_dly), 1);
    tick();
    check("d656_hs", 32'(hs), 0);
    check("d656_hs_dly", 32'(hs_dly), 1);
    tick();
    check("d657_hs_dly", 32'(hs_dly), 1);
    tick();
    check("d658_hs_dly", 32'(hs_dly), 0);
    run_until(10'd751, 10'd1, 200);
    check("d751_hs", 32'(hs), 0);
    check("d751_hs_dly", 32'(hs_dly), 0);
    tick();
    check("d752_hs", 32'(hs), 1);
    check("d752_hs_dly", 32'(hs_dly), 0);
    tick();
    check("d753_hs_dly", 32'(hs_dly), 0);
    tick();
    check("d754_hs_dly", 32'(hs_dly), 1);

    // vs edge and its delayed copy at the start of line 8.
    run_until(10'd799, 10'd7, 8000);
    check("v7_vs", 32'(vs), 1);
    tick();
    check("v8x0_vs", 32'(vs), 0);
    check("v8x0_vs_dly", 32'(vs_dly), 1);
    tick();
    check("v8x1_vs_dly", 32'(vs_dly), 1);
    tick();
    check("v8x2_vs_dly", 32'(vs_dly), 0);

    // Frame wrap: (799,12) -> (0,0) in one clock.
    run_until(10'd799, 10'd12, 4000);
    check("wrap_pre_blank", 32'(blank), 0);
    tick();
    check("wrap_x", 32'(draw_x), 0);
    check("wrap_y", 32'(draw_y), 0);
    check("wrap_fs", 32'(frame_start), 1);
    check("wrap_fs_period", 32'(cyc - 1), FrameClks);
    check("wrap_fc", 32'(frame_count), FcEn ? 2 : 0);

    // One full frame of measurements.
    vs_lo = 0; vs_dly_lo = 0; vs_min = 1023; vs_max = -1; blank_dly_hi = 0; fs_cnt = 0;
    blank_hi = 0; blank_bad = 0;
    for (int i = 0; i < int'(FrameClks); i++) begin
      tick();
      if (!vs) begin
        vs_lo++;
        if (int'(draw_y) < vs_min) vs_min = int'(draw_y);
        if (int'(draw_y) > vs_max) vs_max = int'(draw_y);
      end
      if (!vs_dly) vs_dly_lo++;
      if (blank) blank_hi++;
      if (blank_dly) blank_dly_hi++;
      if (blank && draw_y >= 10'd6) blank_bad++;
      if (frame_start) fs_cnt++;
    end
    check("frm_vs_lo", 32'(vs_lo), 1600);
    check("frm_vs_min", 32'(vs_min), 8);
    check("frm_vs_max", 32'(vs_max), 9);
    check("frm_vs_dly_lo", 32'(vs_dly_lo), 1600);
    check("frm_blank_hi", 32'(blank_hi), 3840);
    check("frm_blank_dly_hi", 32'(blank_dly_hi), 3840);
    check("frm_blank_vblank", 32'(blank_bad), 0);
    check("frm_fs_cnt", 32'(fs_cnt), 1);
    check("frm3_fs", 32'(frame_start), 1);
    check("frm3_fc", 32'(frame_count), FcEn ? 3 : 0);

    // Mid-frame reset for one clock.
    run_until(10'd300, 10'd3, 4000);
    check("pre_mid_blank", 32'(blank), 1);
    reset_n = 1'b0;
    #1;
    check_reset_values("mid");
    tick();
    reset_n = 1'b1;
    check_reset_values("mid_held");
    tick();
    check("post_x", 32'(draw_x), 0);
    check("post_y", 32'(draw_y), 0);
    check("post_blank", 32'(blank), 1);
    check("post_fs", 32'(frame_start), 1);
    check("post_fc", 32'(frame_count), FcEn ? 1 : 0);
    tick();
    check("post2_x", 32'(draw_x), 1);
    check("post2_fs", 32'(frame_start), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
